// File: rtl/mem_stage_controller.sv
// MEM-stage requester: turns load/store strobes into a req/ack transaction to a
// word-organised data memory, stalling the pipeline until completion or timeout.
module mem_stage_controller #(
  parameter int unsigned BASE_ADDR = 1024,
  parameter int unsigned MEM_WORDS = 64,
  parameter int unsigned AW        = 6,
  parameter int unsigned TIMEOUT   = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mem_r_en,
  input  logic          mem_w_en,
  input  logic [31:0]   address,
  input  logic [31:0]   wdata,
  output logic          freeze,
  output logic [31:0]   rdata,
  output logic          err,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  input  logic          mem_ack
);

  localparam int unsigned CW       = 8;
  localparam logic [31:0] SPAN     = 32'(MEM_WORDS * 4);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          req_q, req_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;

  logic [31:0]   off;
  logic          in_range;
  logic          strobe;

  // Below-base addresses wrap to a large offset and fall out of range.
  assign off      = address - 32'(BASE_ADDR);
  assign in_range = (off < SPAN);
  assign strobe   = mem_r_en | mem_w_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (strobe && in_range) state_d = S_WAIT;
      S_WAIT:  if (mem_ack || (cnt_q == CNT_LAST)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // An ack in the expiry cycle takes priority over the timeout.
  always_comb begin
    freeze  = 1'b0;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (strobe) begin
          if (in_range) begin
            freeze  = 1'b1;
            req_d   = 1'b1;
            we_d    = mem_w_en;
            addr_d  = off[AW+1:2];
            wdata_d = wdata;
            cnt_d   = '0;
          end else begin
            err_d = 1'b1;
            if (!mem_w_en) rdata_d = '0;
          end
        end
      end
      S_WAIT: begin
        freeze = 1'b1;
        if (mem_ack) begin
          req_d = 1'b0;
          if (!we_q) rdata_d = mem_rdata;
        end else if (cnt_q == CNT_LAST) begin
          req_d = 1'b0;
          err_d = 1'b1;
          if (!we_q) rdata_d = '0;
        end else begin
          cnt_d = CW'(cnt_q + 1'b1);
        end
      end
      default: ;
    endcase
  end

  assign rdata     = rdata_q;
  assign err       = err_q;
  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_stage_controller.sv
// Scoreboard bench for mem_stage_controller: stimulus queues expected requests
// and results, a negedge monitor pops and compares when the DUT presents them.
module tb_mem_stage_controller;

  localparam int unsigned BASE    = 1024;
  localparam int unsigned TIMEOUT = 15;

  typedef struct packed {
    logic        we;
    logic [5:0]  addr;
    logic [31:0] wd;
  } req_t;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
    logic [31:0] req_len;
  } res_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_r_en, mem_w_en;
  logic [31:0] address, wdata;
  logic        freeze;
  logic [31:0] rdata;
  logic        err;
  logic        mem_req, mem_we;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_ack;

  req_t req_q[$];
  res_t res_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  logic [31:0] mdl_rdata = '0;
  logic prev_req = 1'b0;
  int   run_len  = 0;

  mem_stage_controller #(
    .BASE_ADDR(1024), .MEM_WORDS(64), .AW(6), .TIMEOUT(15)
  ) dut (
    .clk(clk), .rst(rst),
    .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .address(address), .wdata(wdata),
    .freeze(freeze), .rdata(rdata), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: request launch on mem_req rise, result on err or mem_req fall.
  always @(negedge clk) begin
    req_t rq;
    res_t rs;
    if (rst) begin
      prev_req = 1'b0;
      run_len  = 0;
    end else begin
      if (mem_req && !prev_req) begin
        if (req_q.size() == 0) chk("unexpected_req", 32'(mem_req), 32'd0);
        else begin
          rq = req_q.pop_front();
          chk("mem_we",    32'(mem_we),   32'(rq.we));
          chk("mem_addr",  32'(mem_addr), 32'(rq.addr));
          chk("mem_wdata", mem_wdata,     rq.wd);
        end
      end
      if (mem_req) run_len++;
      if (err || (prev_req && !mem_req)) begin
        if (res_q.size() == 0) chk("unexpected_result", 32'(err), 32'd0);
        else begin
          rs = res_q.pop_front();
          chk("err",          32'(err),     32'(rs.err));
          chk("rdata",        rdata,        rs.rdata);
          chk("mem_req_len",  32'(run_len), rs.req_len);
          chk("done_freeze",  32'(freeze),  32'd0);
        end
        run_len = 0;
      end
      prev_req = mem_req;
    end
  end

  // Called at posedge+1; strobes stay up through WAIT and DONE like a frozen pipeline.
  task automatic access(input bit w, input bit r, input logic [31:0] a,
                        input logic [31:0] wd, input int ack_at, input logic [31:0] rd);
    logic [31:0] off;
    req_t rq;
    res_t rs;
    int fc, waits;
    off = a - 32'(BASE);
    mem_w_en = w; mem_r_en = r; address = a; wdata = wd;
    fc = 0;
    if (off < 32'd256) begin
      waits = (ack_at > 0) ? ack_at : int'(TIMEOUT);
      rq.we = w; rq.addr = off[7:2]; rq.wd = wd;
      req_q.push_back(rq);
      if (!w) mdl_rdata = (ack_at > 0) ? rd : 32'd0;
      rs.err = (ack_at == 0); rs.rdata = mdl_rdata; rs.req_len = 32'(waits);
      res_q.push_back(rs);
      @(negedge clk); if (freeze) fc++;
      @(posedge clk); #1;
      for (int k = 1; k <= waits; k++) begin
        mem_ack   = (k == ack_at);
        mem_rdata = (k == ack_at) ? rd : 32'hFFFF_FFFF;
        @(negedge clk); if (freeze) fc++;
        @(posedge clk); #1;
        mem_ack = 1'b0;
      end
      chk("freeze_len", 32'(fc), 32'(waits + 1));
      @(negedge clk);
      @(posedge clk); #1;
      mem_w_en = 1'b0; mem_r_en = 1'b0;
    end else begin
      if (!w) mdl_rdata = '0;
      rs.err = 1'b1; rs.rdata = mdl_rdata; rs.req_len = 32'd0;
      res_q.push_back(rs);
      @(negedge clk); chk("oor_freeze", 32'(freeze), 32'd0);
      @(posedge clk); #1;
      mem_w_en = 1'b0; mem_r_en = 1'b0;
      @(negedge clk); chk("oor_no_req", 32'(mem_req), 32'd0);
      @(posedge clk); #1;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_freeze"},    32'(freeze),    32'd0);
    chk({tag, "_rdata"},     rdata,          32'd0);
    chk({tag, "_err"},       32'(err),       32'd0);
    chk({tag, "_mem_req"},   32'(mem_req),   32'd0);
    chk({tag, "_mem_we"},    32'(mem_we),    32'd0);
    chk({tag, "_mem_addr"},  32'(mem_addr),  32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata,      32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    req_t rq;
    rst = 1'b1; mem_r_en = 1'b0; mem_w_en = 1'b0; address = '0; wdata = '0;
    mem_rdata = '0; mem_ack = 1'b0;
    @(negedge clk); chk_all_zero("reset");
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;

    access(1'b0, 1'b1, 32'd1024, 32'd0,        3, 32'hDEADBEEF);
    access(1'b1, 1'b0, 32'd1028, 32'h12345678, 1, 32'h0);
    access(1'b0, 1'b1, 32'd1020, 32'd0,        0, 32'h0);
    access(1'b0, 1'b1, 32'd1276, 32'd0,        2, 32'hCAFEF00D);
    access(1'b1, 1'b0, 32'd2000, 32'hAAAA5555, 0, 32'h0);
    access(1'b0, 1'b1, 32'd1280, 32'd0,        0, 32'h0);
    access(1'b0, 1'b1, 32'd1277, 32'd0,        1, 32'h0BADC0DE);

    // Stray ack while idle must not start or complete anything.
    mem_ack = 1'b1; mem_rdata = 32'h11111111;
    @(posedge clk); #1; mem_ack = 1'b0;
    @(negedge clk);
    chk("idle_ack_rdata", rdata, mdl_rdata);
    chk("idle_ack_req",   32'(mem_req), 32'd0);
    @(posedge clk); #1;

    access(1'b1, 1'b1, 32'd1036, 32'h87654321, 2, 32'h0);
    access(1'b0, 1'b1, 32'd1100, 32'd0,        0, 32'h0);
    access(1'b0, 1'b1, 32'd1200, 32'd0,       15, 32'h5A5A5A5A);

    // Reset in the middle of WAIT: request drops, no err, then a clean access.
    rq.we = 1'b0; rq.addr = 6'd4; rq.wd = 32'd0;
    req_q.push_back(rq);
    mem_r_en = 1'b1; address = 32'd1040; wdata = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1; mem_r_en = 1'b0;
    @(negedge clk); chk_all_zero("midwait_reset");
    @(posedge clk); #1; rst = 1'b0; mdl_rdata = '0;
    @(negedge clk);
    chk("post_reset_err", 32'(err),     32'd0);
    chk("post_reset_req", 32'(mem_req), 32'd0);
    @(posedge clk); #1;
    access(1'b0, 1'b1, 32'd1032, 32'd0, 2, 32'h600DF00D);

    repeat (3) @(posedge clk);
    #1;
    chk("req_q_drained", 32'(req_q.size()), 32'd0);
    chk("res_q_drained", 32'(res_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_stage_controller.md
Name: mem_stage_controller

Overview:
- Requester-side controller in the MEM stage that turns the pipeline's load/store strobes into a request/acknowledge transaction toward a word-organised data memory.
- Translates byte addresses into word indices and stalls the pipeline until the memory acknowledges.
- Reports out-of-range accesses and timeouts, and returns load data to write-back.

Parameters:
- BASE_ADDR, 1024: byte address of data-memory word 0.
- MEM_WORDS, 64: number of 32-bit words behind the memory port (power of two).
- AW, 6: word-index width, equal to log2(MEM_WORDS).
- TIMEOUT, 15: maximum number of wait cycles for mem_ack before the access is abandoned (1..255).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- mem_r_en  in  1  pipeline requests a load this cycle
- mem_w_en  in  1  pipeline requests a store this cycle; wins if asserted together with mem_r_en
- address  in  32  byte address (ALU result)
- wdata  in  32  store data
- freeze  out  1  stall request to upstream pipeline registers
- rdata  out  32  load result, registered
- err  out  1  one-cycle pulse on a range error or timeout
- mem_req  out  1  request to the memory, registered
- mem_we  out  1  1 = write, 0 = read; valid while mem_req is high
- mem_addr  out  AW  word index
- mem_wdata  out  32  write data
- mem_rdata  in  32  read data from memory; valid in the cycle mem_ack is high
- mem_ack  in  1  memory completion strobe

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - State goes to IDLE and the wait counter clears.
  - freeze, rdata, err, mem_req, mem_we, mem_addr and mem_wdata all go to 0.
- Address translation:
  - off = address - BASE_ADDR, computed in 32-bit unsigned arithmetic.
  - in_range = (off < MEM_WORDS*4). An address below the base wraps to a large value and is out of range.
  - Word index = off[AW+1:2]. The low two address bits are ignored; there are no byte lanes.
- States: IDLE, WAIT, DONE.
- IDLE, when (mem_r_en | mem_w_en) and in_range:
  - Latch mem_addr, mem_we = mem_w_en, mem_wdata = wdata.
  - Set mem_req = 1 and clear the wait counter.
  - Go to WAIT.
- IDLE, when (mem_r_en | mem_w_en) and not in_range:
  - No memory request is issued.
  - Next cycle: err = 1 for exactly one cycle; rdata = 0 on a load and unchanged on a store.
  - Stay in IDLE; freeze is never asserted.
- IDLE with no strobe: hold all outputs except that err returns to 0.
- freeze is combinational:
  - freeze = (IDLE & (mem_r_en|mem_w_en) & in_range) | WAIT.
  - The stall therefore begins in the same cycle the access is presented.
- WAIT:
  - mem_req, mem_we, mem_addr and mem_wdata hold stable until the cycle mem_ack is sampled high.
  - On mem_ack: clear mem_req. On a read, capture rdata = mem_rdata; on a write, leave rdata unchanged. Go to DONE.
  - If there is no ack, increment the counter.
  - When the counter reaches TIMEOUT-1 with no ack: clear mem_req, set err = 1 for one cycle, set rdata = 0 if the access was a read, go to DONE.
  - Minimum latency: an ack in the first WAIT cycle gives 1 WAIT cycle plus 1 DONE cycle.
- DONE:
  - freeze = 0 so the pipeline advances and captures rdata at the end of this cycle.
  - Strobes are ignored, because they still belong to the completing instruction.
  - Next state is IDLE.
- mem_ack outside WAIT is ignored.
- A mem_ack arriving in the same cycle as the timeout expiry counts as an ack; no err is raised.
- Back-to-back accesses: the new access is accepted in the IDLE cycle following DONE, so there are at least 3 cycles per access.
- Reset during WAIT: mem_req drops immediately and no err is raised. Memory-side abandonment on reset is the responder's concern.

Test Plan:
- Read at 1024 (0x400), ack on the 3rd WAIT cycle with mem_rdata = 0xDEADBEEF → mem_addr = 0, mem_we = 0, freeze high for 4 cycles (IDLE plus 3 WAIT), DONE cycle has freeze = 0, rdata = 0xDEADBEEF, err = 0.
- Write to 1028 with wdata = 0x12345678, ack in the 1st WAIT cycle → mem_req high for 1 cycle, mem_addr = 1, mem_we = 1, mem_wdata = 0x12345678, rdata unchanged.
- Read at 1020 and then at 1280 (both out of range) → mem_req stays 0, freeze stays 0, err pulses one cycle each, rdata = 0.
- Read at 1276 (0x4FC, last word) → mem_addr = 63; an address of 1277 also maps to mem_addr = 63.
- Read with no ack, TIMEOUT = 15 → mem_req high for 15 cycles then drops, err pulses once, rdata = 0, freeze released in DONE.
- Assert rst for 1 cycle mid-WAIT, then issue a fresh read at 1032 → all outputs are 0 during reset, no err; the next access completes normally with mem_addr = 2.
